// File: rtl/im_fetch_sched.sv
// im_fetch_sched: owns the PC and arbitrates the single combinational IM read
// port between CPU instruction fetch (priority) and a debug read-back port.
// A pending debug request that keeps losing to fetch is force-granted after
// STARVE_MAX waiting cycles.
//
// Optional feature: define IFU_FETCH_CNT_EN to build the fetch counter.
// Without it, fetch_cnt is tied to zero and no counter flops exist.
module im_fetch_sched #(
    parameter logic [31:0] PC_RESET   = 32'h0000_3000,
    parameter logic [31:0] IM_BASE    = 32'h0000_3000,
    parameter int          IM_AW      = 10,
    parameter int          STARVE_MAX = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [1:0]       npc_sel,
    input  logic             br_taken,
    input  logic [15:0]      imm16,
    input  logic [25:0]      imm26,
    input  logic [31:0]      jr_target,
    output logic [IM_AW-1:0] im_addr,
    input  logic [31:0]      im_instr,
    output logic [31:0]      pc,
    output logic [31:0]      pc4,
    output logic [31:0]      instr,
    output logic             instr_valid,
    input  logic             dbg_req,
    input  logic [IM_AW-1:0] dbg_addr,
    output logic             dbg_valid,
    output logic [31:0]      dbg_rdata,
    output logic             addr_err,
    output logic [31:0]      fetch_cnt
);

    localparam int          SW     = $clog2(STARVE_MAX + 1);
    localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'd4 << IM_AW);

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_DBG  = 2'b10,
        ST_HALT = 2'b11
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic [31:0]       pc_r;
    logic [31:0]       pc_nx_s;
    logic [31:0]       npc_s;
    logic [31:0]       pc4_s;
    logic [SW-1:0]     starve_r;
    logic [SW-1:0]     starve_nx_s;
    logic              dbg_valid_r;
    logic [31:0]       dbg_rdata_r;
    logic              addr_err_r;
    logic              req_s;
    logic              bad_pc_s;
    logic              fetch_s;
    logic [IM_AW-1:0]  pc_widx_s;

    // PC outside the IM window or not word aligned
    function automatic logic pc_bad(input logic [31:0] p);
        pc_bad = (p[1:0] != 2'b00) ||
                 ({1'b0, p} < {1'b0, IM_BASE}) ||
                 ({1'b0, p} >= IM_END);
    endfunction

    // The request stays high during its own dbg_valid cycle; ignore it there so
    // one grant yields exactly one read.
    assign req_s     = dbg_req & ~dbg_valid_r;
    assign bad_pc_s  = pc_bad(pc_r);
    assign pc4_s     = pc_r + 32'd4;
    assign pc_widx_s = pc_r[IM_AW+1:2] - IM_BASE[IM_AW+1:2];

    // Next sequential PC from the controller's npc selection
    always_comb begin
        npc_s = pc4_s;
        case (npc_sel)
            2'b00:   npc_s = pc4_s;
            2'b01: begin
                if (br_taken) begin
                    npc_s = pc4_s + {{14{imm16[15]}}, imm16, 2'b00};
                end else begin
                    npc_s = pc4_s;
                end
            end
            2'b10:   npc_s = {pc4_s[31:28], imm26, 2'b00};
            2'b11:   npc_s = jr_target;
            default: npc_s = pc4_s;
        endcase
    end

    // Scheduler next state, PC advance and starvation tracking
    always_comb begin
        state_nx_s  = state_r;
        pc_nx_s     = pc_r;
        starve_nx_s = starve_r;
        fetch_s     = 1'b0;
        case (state_r)
            ST_BOOT: state_nx_s = ST_RUN;
            ST_RUN: begin
                if (bad_pc_s) begin
                    state_nx_s = ST_HALT;
                end else if (req_s && stall) begin
                    state_nx_s = ST_DBG;
                end else if (req_s && (starve_r == SW'(STARVE_MAX))) begin
                    state_nx_s = ST_DBG;
                end else begin
                    fetch_s     = ~stall;
                    starve_nx_s = req_s ? (starve_r + SW'(1)) : '0;
                    if (!stall) begin
                        pc_nx_s = npc_s;
                    end else begin
                        pc_nx_s = pc_r;
                    end
                end
            end
            ST_DBG: begin
                starve_nx_s = '0;
                state_nx_s  = addr_err_r ? ST_HALT : ST_RUN;
            end
            ST_HALT: begin
                if (req_s) begin
                    state_nx_s = ST_DBG;
                end else begin
                    state_nx_s = ST_HALT;
                end
            end
            default: state_nx_s = ST_BOOT;
        endcase
    end

    // State, PC and debug/error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_BOOT;
            pc_r        <= PC_RESET;
            starve_r    <= '0;
            dbg_valid_r <= 1'b0;
            dbg_rdata_r <= 32'h0;
            addr_err_r  <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            pc_r        <= pc_nx_s;
            starve_r    <= starve_nx_s;
            dbg_valid_r <= (state_r == ST_DBG);
            if (state_r == ST_DBG) begin
                dbg_rdata_r <= im_instr;
            end
            if ((state_r == ST_RUN) && bad_pc_s) begin
                addr_err_r <= 1'b1;
            end
        end
    end

`ifdef IFU_FETCH_CNT_EN
    logic [31:0] fetch_cnt_r;

    // Wrapping count of real fetches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_r <= 32'h0;
        end else if (fetch_s) begin
            fetch_cnt_r <= fetch_cnt_r + 32'd1;
        end
    end

    assign fetch_cnt = fetch_cnt_r;
`else
    assign fetch_cnt = 32'h0;
`endif

    assign im_addr     = (state_r == ST_DBG) ? dbg_addr : pc_widx_s;
    assign instr_valid = fetch_s;
    assign instr       = fetch_s ? im_instr : 32'h0;
    assign pc          = pc_r;
    assign pc4         = pc4_s;
    assign dbg_valid   = dbg_valid_r;
    assign dbg_rdata   = dbg_rdata_r;
    assign addr_err    = addr_err_r;

endmodule
